// File: rtl/gpio_pkg.sv
// Shared constants, counter sizing and debounce FSM encoding for the GPIO
// input conditioning stage.
package gpio_pkg;

    localparam int unsigned GPIO_WIDTH_DEF           = 32'd8;
    localparam int unsigned GPIO_SYNC_STAGES_DEF     = 32'd2;
    localparam int unsigned GPIO_DEBOUNCE_CYCLES_DEF = 32'd50000;

    typedef enum logic {
        DB_STABLE   = 1'b0,
        DB_COUNTING = 1'b1
    } db_state_e;

    // Counter width for a debounce window of n cycles: max(1, clog2(n)).
    function automatic int unsigned db_cnt_width(input int unsigned n);
        int unsigned w;
        w = 32'($clog2(n));
        return (w < 32'd1) ? 32'd1 : w;
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One GPIO bit: synchronizer chain, debounce FSM with dwell counter, and an
// optional registered acceptance pulse (built only with GPIO_IN_CHANGE_EN).
module debounce_bit
    import gpio_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = GPIO_SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = GPIO_DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic pad_i,
    output logic stable_o,
    output logic changed_o
);

    localparam int unsigned    CNT_W           = db_cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
    // The counter holds the number of differing cycles already seen, so the
    // level is accepted on the cycle that would make it DEBOUNCE_CYCLES.
    localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(DEBOUNCE_CYCLES - 32'd1);
    localparam bit             ACCEPT_ON_FIRST = (DEBOUNCE_CYCLES == 32'd1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   sync_bit;

    db_state_e              state_q;
    db_state_e              state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   stable_q;
    logic                   stable_d;
    logic                   accept_c;

    // Shift the raw pad level through the synchronizer chain.
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], pad_i};
        sync_bit = sync_q[SYNC_STAGES-1];
    end

    // Debounce FSM next-state: count consecutive differing cycles, drop on glitch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_c = 1'b0;
        unique case (state_q)
            DB_STABLE: begin
                if (sync_bit != stable_q) begin
                    if (ACCEPT_ON_FIRST) begin
                        accept_c = 1'b1;
                    end else begin
                        state_d = DB_COUNTING;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            DB_COUNTING: begin
                if (sync_bit == stable_q) begin
                    state_d = DB_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    accept_c = 1'b1;
                    state_d  = DB_STABLE;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = DB_STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Acceptance only ever fires while the bit differs, so it is a toggle.
    assign stable_d = stable_q ^ accept_c;

    // Synchronizer, FSM, counter and accepted level registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= '0;
            state_q  <= DB_STABLE;
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_o = stable_q;

`ifdef GPIO_IN_CHANGE_EN
    logic changed_q;

    // One-cycle pulse registered on the same edge the accepted level updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= accept_c;
        end
    end

    assign changed_o = changed_q;
`else
    assign changed_o = 1'b0;
`endif

endmodule

// File: rtl/gpio_in_debounce.sv
// GPIO input conditioning in front of the datapath GPIO_i port: per-bit
// synchronize + debounce, with an optional change event and mask.
// Change event logic is built only when GPIO_IN_CHANGE_EN is defined;
// otherwise change_o / change_mask_o are constant 0.
module gpio_in_debounce
    import gpio_pkg::*;
#(
    parameter int unsigned WIDTH           = GPIO_WIDTH_DEF,
    parameter int unsigned SYNC_STAGES     = GPIO_SYNC_STAGES_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = GPIO_DEBOUNCE_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] gpio_pad_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic             change_o,
    output logic [WIDTH-1:0] change_mask_o
);

    logic [WIDTH-1:0] stable_w;
    logic [WIDTH-1:0] changed_w;

    // Independent conditioning channel per GPIO bit.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_bit (
            .clk       (clk),
            .reset     (reset),
            .pad_i     (gpio_pad_i[i]),
            .stable_o  (stable_w[i]),
            .changed_o (changed_w[i])
        );
    end

    // Outputs come straight from per-bit flops; change_o merges same-edge pulses.
    assign gpio_o        = stable_w;
    assign change_mask_o = changed_w;
    assign change_o      = |changed_w;

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Scoreboard bench for gpio_in_debounce (SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
module tb_gpio_in_debounce;

    localparam int unsigned W  = 8;
    localparam int unsigned SS = 2;
    localparam int          DC = 4;
`ifdef GPIO_IN_CHANGE_EN
    localparam bit CHG_EN = 1'b1;
`else
    localparam bit CHG_EN = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] gpio;
        logic [W-1:0] mask;
    } evt_t;

    logic         clk   = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] pad   = '0;
    logic [W-1:0] gpio_o;
    logic [W-1:0] mask_o;
    logic         change_o;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;
    bit mon_en = 1'b0;

    // Reference model state: pad delay line, window of levels seen by the
    // debouncer, expected outputs and pending expected events.
    logic [W-1:0] pipe_q[$];
    logic [W-1:0] hist_q[$];
    logic [W-1:0] m_gpio = '0;
    logic [W-1:0] m_mask = '0;
    evt_t         evt_q[$];

    always #5 clk = ~clk;

    gpio_in_debounce #(
        .WIDTH           (W),
        .SYNC_STAGES     (SS),
        .DEBOUNCE_CYCLES (DC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .gpio_pad_i    (pad),
        .gpio_o        (gpio_o),
        .change_o      (change_o),
        .change_mask_o (mask_o)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model: a bit flips once its synchronized level has differed from the
    // accepted level for DC consecutive cycles.
    always @(posedge clk) begin : model
        logic [W-1:0] seen;
        logic [W-1:0] acc;
        bit           all_diff;
        if (reset) begin
            pipe_q.delete();
            for (int s = 0; s < int'(SS); s++) pipe_q.push_back('0);
            hist_q.delete();
            m_gpio = '0;
            m_mask = '0;
        end else begin
            seen = pipe_q.pop_front();
            pipe_q.push_back(pad);
            hist_q.push_back(seen);
            if (hist_q.size() > DC) void'(hist_q.pop_front());
            acc = '0;
            if (hist_q.size() == DC) begin
                for (int i = 0; i < int'(W); i++) begin
                    all_diff = 1'b1;
                    foreach (hist_q[j]) if (hist_q[j][i] == m_gpio[i]) all_diff = 1'b0;
                    acc[i] = all_diff;
                end
            end
            m_gpio = m_gpio ^ acc;
            m_mask = CHG_EN ? acc : '0;
            if (m_mask != '0) evt_q.push_back('{gpio: m_gpio, mask: m_mask});
        end
    end

    // Monitor: compare every cycle, and pop an expected event on each pulse.
    always @(negedge clk) begin : monitor
        evt_t e;
        if (mon_en) begin
            check("gpio_o", gpio_o, m_gpio);
            check("change_mask_o", mask_o, m_mask);
            check("change_o", W'(change_o), W'(m_mask != '0));
            if (change_o) begin
                pulse_cnt++;
                if (evt_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL event: unexpected pulse, mask %h with none expected at %0t", mask_o, $time);
                end else begin
                    e = evt_q.pop_front();
                    check("event_mask", mask_o, e.mask);
                    check("event_gpio", gpio_o, e.gpio);
                end
            end
        end
    end

    initial begin
        int p0;
        reset = 1'b1;
        pad   = '0;
        tick(3);
        check("reset_gpio", gpio_o, 8'h00);
        check("reset_change", W'(change_o), 8'h00);
        check("reset_mask", mask_o, 8'h00);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Single bit rise: accepted exactly 6 edges after the pad edge.
        pad = 8'h01;
        tick(5);
        check("s1_before", gpio_o, 8'h00);
        tick(1);
        check("s1_gpio", gpio_o, 8'h01);
        check("s1_change", W'(change_o), W'(CHG_EN));
        check("s1_mask", mask_o, CHG_EN ? 8'h01 : 8'h00);
        tick(1);
        check("s1_pulse_end", W'(change_o), 8'h00);
        check("s1_hold", gpio_o, 8'h01);
        pad = 8'h00;
        tick(8);
        check("s1_fall", gpio_o, 8'h00);

        // Glitch of 3 cycles is rejected.
        p0 = pulse_cnt;
        pad = 8'h08;
        tick(3);
        pad = 8'h00;
        tick(10);
        check("glitch_gpio", gpio_o, 8'h00);
        check("glitch_pulses", W'(pulse_cnt - p0), 8'h00);

        // A pulse of exactly 4 cycles is accepted, then released.
        pad = 8'h08;
        tick(4);
        pad = 8'h00;
        tick(2);
        check("min_pulse_accept", gpio_o, 8'h08);
        tick(4);
        check("min_pulse_release", gpio_o, 8'h00);

        // Simultaneous change: one pulse with all bits in the mask.
        p0 = pulse_cnt;
        pad = 8'hA5;
        tick(5);
        check("simul_before", gpio_o, 8'h00);
        tick(1);
        check("simul_gpio", gpio_o, 8'hA5);
        check("simul_mask", mask_o, CHG_EN ? 8'hA5 : 8'h00);
        tick(1);
        check("simul_pulses", W'(pulse_cnt - p0), W'(CHG_EN));
        pad = 8'h00;
        tick(8);
        check("simul_clear", gpio_o, 8'h00);

        // Reset mid-count discards pending acceptance.
        p0 = pulse_cnt;
        pad = 8'hFF;
        tick(3);
        reset = 1'b1;
        tick(1);
        check("rst_mid_gpio", gpio_o, 8'h00);
        check("rst_mid_change", W'(change_o), 8'h00);
        check("rst_mid_mask", mask_o, 8'h00);
        reset = 1'b0;
        tick(5);
        check("rst_mid_wait", gpio_o, 8'h00);
        check("rst_mid_no_evt", W'(pulse_cnt - p0), 8'h00);
        tick(1);
        check("rst_mid_accept", gpio_o, 8'hFF);
        check("rst_mid_mask_ff", mask_o, CHG_EN ? 8'hFF : 8'h00);

        // Release of the top bit.
        pad = 8'h7F;
        tick(5);
        check("rel_before", gpio_o, 8'hFF);
        tick(1);
        check("rel_gpio", gpio_o, 8'h7F);
        check("rel_mask", mask_o, CHG_EN ? 8'h80 : 8'h00);
        tick(1);

        // Randomized holds and bounces, with occasional resets.
        for (int b = 0; b < 400; b++) begin
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b1;
                tick(1);
                reset = 1'b0;
            end
            if ($urandom_range(0, 3) == 0) pad = W'($urandom);
            else pad = pad ^ W'(32'd1 << $urandom_range(0, W - 1));
            tick($urandom_range(1, 9));
        end
        tick(10);
        check("final_settle", gpio_o, pad);
        check("events_drained", W'(evt_q.size()), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
